// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory read channel: request/address from the fetch stage,
// acknowledge/data back from memory.
interface fetch_pc_unit_if #(
  parameter int PCW = 64
);
  logic           req;
  logic [PCW-1:0] addr;
  logic           ack;
  logic [31:0]    rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_pc_unit.sv
// PC register and req/ack instruction fetch feeding IR to the control unit;
// also holds the VCNZ status register.
module fetch_pc_unit #(
  parameter int             PCW      = 64,
  parameter logic [PCW-1:0] RESET_PC = '0,
  parameter int             TIMEOUT  = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fetch,
  input  logic [1:0]       pc_sel,
  input  logic [31:0]      k,
  input  logic [PCW-1:0]   pc_in,
  input  logic             status_load,
  input  logic [3:0]       flags_in,
  fetch_pc_unit_if.master  imem,
  output logic [PCW-1:0]   pc,
  output logic [31:0]      IR,
  output logic             ir_valid,
  output logic             busy,
  output logic             fault,
  output logic [3:0]       status
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_FAULT} state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t         state_reg, state_next;
  logic [7:0]     timer_reg, timer_next;
  logic           req_reg, req_next;
  logic [PCW-1:0] addr_reg, addr_next;
  logic [31:0]    ir_reg, ir_next;
  logic           ir_valid_reg, ir_valid_next;
  logic           fault_reg, fault_next;
  logic [PCW-1:0] pc_reg, pc_next;
  logic [3:0]     status_reg, status_next;
  logic [PCW-1:0] jump_off;

  // Word offset: sign-extend to full PC width before scaling to bytes.
  assign jump_off = PCW'($signed(k)) << 2;

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    req_next      = req_reg;
    addr_next     = addr_reg;
    ir_next       = ir_reg;
    ir_valid_next = 1'b0;
    fault_next    = fault_reg;
    case (state_reg)
      S_IDLE: begin
        if (fetch) begin
          addr_next  = pc_reg;
          req_next   = 1'b1;
          timer_next = '0;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        // A late ack on the final waiting cycle still wins over the timeout.
        if (imem.ack) begin
          ir_next       = imem.rdata;
          req_next      = 1'b0;
          ir_valid_next = 1'b1;
          state_next    = S_DONE;
        end else if (timer_reg == TIMER_LAST) begin
          req_next   = 1'b0;
          fault_next = 1'b1;
          state_next = S_FAULT;
        end else begin
          timer_next = timer_reg + 8'd1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    pc_next = pc_reg;
    case (pc_sel)
      2'b00:   pc_next = pc_reg;
      2'b01:   pc_next = pc_reg + PCW'(4);
      2'b10:   pc_next = pc_reg + jump_off;
      default: pc_next = pc_in;
    endcase
  end

  assign status_next = status_load ? flags_in : status_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      timer_reg    <= '0;
      req_reg      <= 1'b0;
      addr_reg     <= '0;
      ir_reg       <= '0;
      ir_valid_reg <= 1'b0;
      fault_reg    <= 1'b0;
      pc_reg       <= RESET_PC;
      status_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      req_reg      <= req_next;
      addr_reg     <= addr_next;
      ir_reg       <= ir_next;
      ir_valid_reg <= ir_valid_next;
      fault_reg    <= fault_next;
      pc_reg       <= pc_next;
      status_reg   <= status_next;
    end
  end

  assign imem.req  = req_reg;
  assign imem.addr = addr_reg;
  assign pc        = pc_reg;
  assign IR        = ir_reg;
  assign ir_valid  = ir_valid_reg;
  assign busy      = (state_reg != S_IDLE);
  assign fault     = fault_reg;
  assign status    = status_reg;

endmodule
